// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: memory-mapped register addresses and the
// OAM DMA state encoding used by the sprite DMA arbiter.
package nes_bus_pkg;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4
    } dma_state_e;

    // A DMA starts only on a CPU write to $4014 seen while the arbiter is idle.
    function automatic logic is_dma_trigger(input dma_state_e state,
                                            input logic        cpu_we,
                                            input logic [15:0] cpu_address);
        return (state == DMA_IDLE) && cpu_we && (cpu_address == OAMDMA_ADDR);
    endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM sprite DMA arbiter: passes CPU accesses through while idle, and on a
// $4014 write stalls the CPU and copies one 256-byte page to $2004.
module oam_dma_arbiter
    import nes_bus_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    input  logic [7:0]  in,
    output logic [15:0] address,
    output logic [7:0]  out,
    output logic        we,
    output logic        locked,
    output logic        busy,
    output logic        done
);

    dma_state_e state_r;
    dma_state_e state_s;
    logic [7:0] page_r;
    logic [7:0] idx_r;
    logic       parity_r;
    logic       done_r;
    logic       trigger_s;
    logic       last_byte_s;

    assign trigger_s   = is_dma_trigger(state_r, cpu_we, cpu_address);
    assign last_byte_s = (state_r == DMA_WRITE) && (idx_r == 8'hFF);

    // Next-state selection; HALT inserts one ALIGN clock on odd parity.
    always_comb begin
        state_s = state_r;
        case (state_r)
            DMA_IDLE: begin
                if (trigger_s) begin
                    state_s = DMA_HALT;
                end else begin
                    state_s = DMA_IDLE;
                end
            end
            DMA_HALT: begin
                if (parity_r) begin
                    state_s = DMA_ALIGN;
                end else begin
                    state_s = DMA_READ;
                end
            end
            DMA_ALIGN: state_s = DMA_READ;
            DMA_READ:  state_s = DMA_WRITE;
            DMA_WRITE: begin
                if (idx_r == 8'hFF) begin
                    state_s = DMA_IDLE;
                end else begin
                    state_s = DMA_READ;
                end
            end
            default:   state_s = DMA_IDLE;
        endcase
    end

    // State, transfer bookkeeping, parity flag and completion pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= DMA_IDLE;
            page_r   <= 8'h00;
            idx_r    <= 8'h00;
            parity_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            parity_r <= ~parity_r;
            done_r   <= last_byte_s;
            if (trigger_s) begin
                page_r <= cpu_out;
                idx_r  <= 8'h00;
            end else if (state_r == DMA_WRITE) begin
                idx_r  <= idx_r + 8'd1;
            end
        end
    end

    // Bus mux: the CPU owns the bus in IDLE; CPU writes are blocked otherwise.
    always_comb begin
        address = cpu_address;
        out     = cpu_out;
        we      = cpu_we;
        case (state_r)
            DMA_IDLE: begin
                address = cpu_address;
                out     = cpu_out;
                we      = cpu_we;
            end
            DMA_HALT, DMA_ALIGN: begin
                address = cpu_address;
                out     = cpu_out;
                we      = 1'b0;
            end
            DMA_READ: begin
                address = {page_r, idx_r};
                out     = 8'h00;
                we      = 1'b0;
            end
            DMA_WRITE: begin
                address = OAMDATA_ADDR;
                out     = in;
                we      = 1'b1;
            end
            default: begin
                address = cpu_address;
                out     = cpu_out;
                we      = 1'b0;
            end
        endcase
    end

    assign locked = (state_r == DMA_IDLE);
    assign busy   = (state_r != DMA_IDLE);
    assign done   = done_r;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed self-checking bench for oam_dma_arbiter with a registered RAM model.
module tb_oam_dma_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic [7:0]  rd_data;
    logic [15:0] address;
    logic [7:0]  wr_data;
    logic        we;
    logic        locked;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:65535];
    logic        par_m;

    int          n_cmp = 0;
    int          n_mis = 0;

    bit          mon_en = 1'b0;
    int          busy_cnt, lock_cnt, done_cnt, fwd_cnt, zero_cnt;
    logic [15:0] last_rd;
    logic [7:0]  wr_q [$];

    oam_dma_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .in          (rd_data),
        .address     (address),
        .out         (wr_data),
        .we          (we),
        .locked      (locked),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Registered RAM: read data appears one clock after the address.
    always @(posedge clock) begin
        if (we) mem[address] <= wr_data;
        rd_data <= mem[address];
    end

    // Independent parity model: cleared by reset, toggles every clock.
    always @(posedge clock) begin
        par_m <= reset ? 1'b0 : ~par_m;
    end

    function automatic logic [7:0] page_byte(input logic [7:0] pg, input int i);
        logic [7:0] b;
        b = i[7:0];
        return (pg == 8'hFF) ? (b ^ 8'hA5) : (b ^ 8'h5A);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        busy_cnt = 0; lock_cnt = 0; done_cnt = 0; fwd_cnt = 0; zero_cnt = 0;
        last_rd  = 16'h0000;
        wr_q.delete();
    endtask

    // Mid-cycle bus monitor.
    always @(negedge clock) begin
        if (mon_en) begin
            if (busy)    busy_cnt++;
            if (!locked) lock_cnt++;
            if (done)    done_cnt++;
            if (we && address == 16'h2004) wr_q.push_back(wr_data);
            else if (we)                   fwd_cnt++;
            if (busy && address == 16'h0000) zero_cnt++;
            if (busy && !we) last_rd = address;
        end
    end

    // Trigger a DMA so that HALT sees parity want_par, then audit the whole transfer.
    task automatic run_dma(input string tag, input logic [7:0] pg, input logic want_par, input bit poke);
        int cyc;
        @(posedge clock); #1;
        if (par_m == want_par) begin
            @(posedge clock); #1;
        end
        cpu_address = 16'h4014; cpu_out = pg; cpu_we = 1'b1;
        @(posedge clock); #1;
        cpu_we = 1'b0; cpu_address = 16'h8000; cpu_out = 8'hEE;
        clear_mon();
        mon_en = 1'b1;
        if (poke) begin
            repeat (50) @(posedge clock);
            #1;
            cpu_address = 16'h4014; cpu_out = 8'h77; cpu_we = 1'b1;
            @(posedge clock); #1;
            cpu_address = 16'h8000; cpu_we = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 800) begin
            @(posedge clock); #1;
            cyc++;
        end
        repeat (3) @(posedge clock);
        #1;
        mon_en = 1'b0;
        check_eq({tag, "_done_pulses"}, done_cnt, 1);
        check_eq({tag, "_busy_clocks"}, busy_cnt, want_par ? 514 : 513);
        check_eq({tag, "_locked_low_clocks"}, lock_cnt, want_par ? 514 : 513);
        check_eq({tag, "_oam_writes"}, wr_q.size(), 256);
        for (int i = 0; i < 256 && i < wr_q.size(); i++)
            check_eq($sformatf("%s_data%0d", tag, i), wr_q[i], page_byte(pg, i));
        check_eq({tag, "_forwarded_cpu_writes"}, fwd_cnt, 0);
        check_eq({tag, "_zero_accesses"}, zero_cnt, 0);
        check_eq({tag, "_last_read_addr"}, last_rd, {pg, 8'hFF});
        check_eq({tag, "_end_busy"}, busy, 0);
        check_eq({tag, "_end_locked"}, locked, 1);
    endtask

    initial begin
        int cyc;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0300 + i] = page_byte(8'h03, i);
            mem[16'hFF00 + i] = page_byte(8'hFF, i);
        end
        reset = 1'b1; cpu_address = 16'h0000; cpu_out = 8'h00; cpu_we = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_locked", locked, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_we", we, 0);
        reset = 1'b0;

        // IDLE pass-through
        cpu_address = 16'h1234; cpu_out = 8'h5C; cpu_we = 1'b1;
        #1;
        check_eq("pass_addr", address, 16'h1234);
        check_eq("pass_data", wr_data, 8'h5C);
        check_eq("pass_we", we, 1);
        @(posedge clock); #1;
        cpu_we = 1'b0; cpu_address = 16'h8000;
        #1;
        check_eq("pass_we_low", we, 0);

        run_dma("p0", 8'h03, 1'b0, 1'b0);
        run_dma("p1", 8'h03, 1'b1, 1'b0);
        run_dma("pff", 8'hFF, 1'b0, 1'b0);
        run_dma("poke", 8'h03, 1'b1, 1'b1);

        // $4014 read in IDLE must not start a transfer
        @(posedge clock); #1;
        cpu_address = 16'h4014; cpu_out = 8'h03; cpu_we = 1'b0;
        clear_mon();
        mon_en = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        mon_en = 1'b0;
        check_eq("rd4014_busy", busy_cnt, 0);
        check_eq("rd4014_writes", wr_q.size() + fwd_cnt, 0);
        cpu_address = 16'h8000;

        // Abort by reset during the 100th OAM write
        @(posedge clock); #1;
        cpu_address = 16'h4014; cpu_out = 8'h03; cpu_we = 1'b1;
        @(posedge clock); #1;
        cpu_address = 16'h8000; cpu_we = 1'b0;
        clear_mon();
        mon_en = 1'b1;
        cyc = 0;
        while (wr_q.size() < 100 && cyc < 700) begin
            @(negedge clock); #1;
            cyc++;
        end
        check_eq("abort_reached_100", wr_q.size(), 100);
        check_eq("abort_we_at_100th", we, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        cpu_address = 16'h0500; cpu_out = 8'h33; cpu_we = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_locked", locked, 1);
        check_eq("abort_done", done, 0);
        check_eq("abort_we_follows_cpu", we, 1);
        check_eq("abort_addr_follows_cpu", address, 16'h0500);
        @(posedge clock); #1;
        cpu_we = 1'b0; cpu_address = 16'h8000;
        repeat (5) @(posedge clock);
        #1;
        mon_en = 1'b0;
        check_eq("abort_oam_writes", wr_q.size(), 100);
        check_eq("abort_done_pulses", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
